// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with set-instruction resolution,
// a four-bit condition flag register and a RUN/HALTED state machine.
//
// Ports
//   clk, rst            : clock (rising edge) and asynchronous active-high reset
//   ex_valid            : incoming slot holds a real instruction
//   ex_alu_out          : ALU result (WIDTH)
//   ex_zf/of/sf/cf      : flags produced by the ALU for this slot
//   ex_st_data          : store data (WIDTH)
//   ex_wr_reg           : destination register index (3)
//   ex_reg_write, ex_mem_read, ex_mem_write, ex_halt : control bits
//   ex_is_set, ex_setop : set instruction select (00 SEQ, 01 SLT, 10 SLE, 11 SCO)
//   stall, flush        : hold the register / squash the incoming slot
//   mem_*               : registered slot presented to the memory stage
//   flags               : registered {ZF,SF,OF,CF}
//   halted              : high while the state machine is in HALTED
// All outputs come straight from flops.
module ex_mem_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_alu_out,
  input  logic             ex_zf,
  input  logic             ex_of,
  input  logic             ex_sf,
  input  logic             ex_cf,
  input  logic [WIDTH-1:0] ex_st_data,
  input  logic [2:0]       ex_wr_reg,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic             ex_halt,
  input  logic             ex_is_set,
  input  logic [1:0]       ex_setop,
  input  logic             stall,
  input  logic             flush,
  output logic             mem_valid,
  output logic             mem_reg_write,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic             mem_halt,
  output logic [2:0]       mem_wr_reg,
  output logic [WIDTH-1:0] mem_result,
  output logic [WIDTH-1:0] mem_st_data,
  output logic [3:0]       flags,
  output logic             halted
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t           state;
  logic             cond;
  logic [WIDTH-1:0] next_result;

  // Set-instruction condition, evaluated on the flags of the incoming slot.
  always_comb begin
    cond = 1'b0;
    unique case (ex_setop)
      2'b00: cond = ex_zf;
      2'b01: cond = (ex_sf ^ ex_of) & ~ex_zf;
      2'b10: cond = (ex_sf ^ ex_of) | ex_zf;
      2'b11: cond = ex_cf;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    next_result = ex_alu_out;
    if (ex_is_set) next_result = {{(WIDTH-1){1'b0}}, cond};
  end

  // halted is a decode of the state flop, so no input reaches it combinationally.
  assign halted = (state == HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      mem_valid     <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_mem_read  <= 1'b0;
      mem_mem_write <= 1'b0;
      mem_halt      <= 1'b0;
      mem_wr_reg    <= '0;
      mem_result    <= '0;
      mem_st_data   <= '0;
      flags         <= '0;
    end else begin
      unique case (state)
        HALTED: begin
          // Slot contents and flags freeze; only control is cleared.
          mem_valid     <= 1'b0;
          mem_reg_write <= 1'b0;
          mem_mem_read  <= 1'b0;
          mem_mem_write <= 1'b0;
          mem_halt      <= 1'b0;
        end
        RUN: begin
          if (flush) begin
            mem_valid     <= 1'b0;
            mem_reg_write <= 1'b0;
            mem_mem_read  <= 1'b0;
            mem_mem_write <= 1'b0;
            mem_halt      <= 1'b0;
            mem_wr_reg    <= '0;
            mem_result    <= '0;
            mem_st_data   <= '0;
          end else if (!stall) begin
            mem_valid     <= ex_valid;
            mem_reg_write <= ex_valid & ex_reg_write;
            mem_mem_read  <= ex_valid & ex_mem_read;
            mem_mem_write <= ex_valid & ex_mem_write;
            mem_halt      <= ex_valid & ex_halt;
            mem_wr_reg    <= ex_wr_reg;
            mem_result    <= next_result;
            mem_st_data   <= ex_st_data;
            if (ex_valid && !ex_is_set) flags <= {ex_zf, ex_sf, ex_of, ex_cf};
            if (ex_valid && ex_halt) state <= HALTED;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_zf, ex_of, ex_sf, ex_cf;
  logic [15:0] ex_alu_out, ex_st_data;
  logic [2:0]  ex_wr_reg;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_halt, ex_is_set;
  logic [1:0]  ex_setop;
  logic        stall, flush;
  logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_halt;
  logic [2:0]  mem_wr_reg;
  logic [15:0] mem_result, mem_st_data;
  logic [3:0]  flags;
  logic        halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_reg #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
    .ex_zf(ex_zf), .ex_of(ex_of), .ex_sf(ex_sf), .ex_cf(ex_cf),
    .ex_st_data(ex_st_data), .ex_wr_reg(ex_wr_reg),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_halt(ex_halt),
    .ex_is_set(ex_is_set), .ex_setop(ex_setop),
    .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_halt(mem_halt), .mem_wr_reg(mem_wr_reg),
    .mem_result(mem_result), .mem_st_data(mem_st_data),
    .flags(flags), .halted(halted)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ex_valid = 0; ex_alu_out = '0; ex_zf = 0; ex_of = 0; ex_sf = 0; ex_cf = 0;
    ex_st_data = '0; ex_wr_reg = '0; ex_reg_write = 0; ex_mem_read = 0;
    ex_mem_write = 0; ex_halt = 0; ex_is_set = 0; ex_setop = 2'b00;
    stall = 0; flush = 0;
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    ex_valid = 1; ex_alu_out = 16'h7777; ex_reg_write = 1;
    tick(); tick();
    check("rst_valid",  16'(mem_valid), 16'h0);
    check("rst_rw",     16'(mem_reg_write), 16'h0);
    check("rst_result", mem_result, 16'h0000);
    check("rst_flags",  16'(flags), 16'h0);
    check("rst_halted", 16'(halted), 16'h0);

    // Plain ALU load
    rst = 0;
    idle();
    ex_valid = 1; ex_alu_out = 16'h1234; ex_wr_reg = 3'd3; ex_reg_write = 1; ex_cf = 1;
    tick();
    check("ld_result", mem_result, 16'h1234);
    check("ld_wr_reg", 16'(mem_wr_reg), 16'd3);
    check("ld_rw",     16'(mem_reg_write), 16'h1);
    check("ld_valid",  16'(mem_valid), 16'h1);
    check("ld_flags",  16'(flags), 16'h1);

    // SLT true: SF^OF=1, ZF=0
    idle();
    ex_valid = 1; ex_is_set = 1; ex_setop = 2'b01; ex_sf = 1; ex_alu_out = 16'hFFFE;
    tick();
    check("slt_result", mem_result, 16'h0001);
    check("slt_flags",  16'(flags), 16'h1);
    // SEQ false
    idle();
    ex_valid = 1; ex_is_set = 1; ex_setop = 2'b00; ex_alu_out = 16'hFFFF;
    tick();
    check("seq_result", mem_result, 16'h0000);
    // SLE true via ZF alone
    idle();
    ex_valid = 1; ex_is_set = 1; ex_setop = 2'b10; ex_zf = 1; ex_alu_out = 16'h8000;
    tick();
    check("sle_result", mem_result, 16'h0001);
    // SLT false when ZF set even though SF^OF=1
    idle();
    ex_valid = 1; ex_is_set = 1; ex_setop = 2'b01; ex_zf = 1; ex_of = 1;
    tick();
    check("slt_zf_result", mem_result, 16'h0000);
    // SCO
    idle();
    ex_valid = 1; ex_is_set = 1; ex_setop = 2'b11; ex_cf = 1;
    tick();
    check("sco_result", mem_result, 16'h0001);
    check("set_flags",  16'(flags), 16'h1);

    // Bubble: controls forced low, data captured, flags preserved
    idle();
    ex_valid = 0; ex_alu_out = 16'h5555; ex_reg_write = 1; ex_mem_write = 1; ex_zf = 1;
    tick();
    check("bub_valid",  16'(mem_valid), 16'h0);
    check("bub_rw",     16'(mem_reg_write), 16'h0);
    check("bub_mw",     16'(mem_mem_write), 16'h0);
    check("bub_result", mem_result, 16'h5555);
    check("bub_flags",  16'(flags), 16'h1);

    // Store load with ZF=1 -> flags 1000
    idle();
    ex_valid = 1; ex_mem_write = 1; ex_st_data = 16'hABCD; ex_alu_out = 16'h0100;
    ex_wr_reg = 3'd6; ex_zf = 1;
    tick();
    check("st_mw",    16'(mem_mem_write), 16'h1);
    check("st_data",  mem_st_data, 16'hABCD);
    check("st_flags", 16'(flags), 16'h8);

    // Stall three cycles with changing inputs
    for (int unsigned i = 0; i < 3; i++) begin
      idle();
      stall = 1; ex_valid = 1; ex_alu_out = 16'(16'h0F00 + i); ex_st_data = 16'(i);
      ex_reg_write = 1; ex_cf = 1; ex_wr_reg = 3'd1;
      tick();
      check("stall_result", mem_result, 16'h0100);
      check("stall_st",     mem_st_data, 16'hABCD);
      check("stall_mw",     16'(mem_mem_write), 16'h1);
      check("stall_rw",     16'(mem_reg_write), 16'h0);
      check("stall_wr_reg", 16'(mem_wr_reg), 16'd6);
      check("stall_flags",  16'(flags), 16'h8);
    end

    // Stall + flush -> flush wins
    idle();
    stall = 1; flush = 1; ex_valid = 1; ex_alu_out = 16'h4444; ex_reg_write = 1; ex_cf = 1;
    tick();
    check("fl_valid",  16'(mem_valid), 16'h0);
    check("fl_result", mem_result, 16'h0000);
    check("fl_st",     mem_st_data, 16'h0000);
    check("fl_mw",     16'(mem_mem_write), 16'h0);
    check("fl_flags",  16'(flags), 16'h8);

    // Halt slot, SF=1 -> flags 0100
    idle();
    ex_valid = 1; ex_halt = 1; ex_alu_out = 16'hBEEF; ex_sf = 1; ex_wr_reg = 3'd2;
    tick();
    check("h_halt",   16'(mem_halt), 16'h1);
    check("h_valid",  16'(mem_valid), 16'h1);
    check("h_halted", 16'(halted), 16'h1);
    check("h_result", mem_result, 16'hBEEF);
    check("h_flags",  16'(flags), 16'h4);

    // In HALTED: inputs ignored
    idle();
    ex_valid = 1; ex_reg_write = 1; ex_alu_out = 16'h1111; ex_cf = 1;
    tick();
    check("hd_valid",  16'(mem_valid), 16'h0);
    check("hd_rw",     16'(mem_reg_write), 16'h0);
    check("hd_halt",   16'(mem_halt), 16'h0);
    check("hd_halted", 16'(halted), 16'h1);
    check("hd_result", mem_result, 16'hBEEF);
    check("hd_wr_reg", 16'(mem_wr_reg), 16'd2);
    check("hd_flags",  16'(flags), 16'h4);
    flush = 1;
    tick();
    check("hd_flush_result", mem_result, 16'hBEEF);
    check("hd_flush_halted", 16'(halted), 16'h1);

    // Async reset between edges
    idle();
    #2;
    rst = 1;
    #1;
    check("ar_result", mem_result, 16'h0000);
    check("ar_halted", 16'(halted), 16'h0);
    check("ar_flags",  16'(flags), 16'h0);
    check("ar_wr_reg", 16'(mem_wr_reg), 16'd0);
    tick();
    rst = 0;
    ex_valid = 1; ex_alu_out = 16'h2222; ex_wr_reg = 3'd5; ex_reg_write = 1; ex_of = 1;
    tick();
    check("post_result", mem_result, 16'h2222);
    check("post_wr_reg", 16'(mem_wr_reg), 16'd5);
    check("post_valid",  16'(mem_valid), 16'h1);
    check("post_rw",     16'(mem_reg_write), 16'h1);
    check("post_flags",  16'(flags), 16'h2);
    check("post_halted", 16'(halted), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width of result and store data.
REQ-002 SHALL have input clk, 1 bit, sole clock; all state updates on rising edge.
REQ-003 SHALL have input rst, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have inputs ex_valid (1), ex_alu_out (WIDTH), ex_zf, ex_of, ex_sf, ex_cf (1 each): execute-stage result and flags.
REQ-005 SHALL have inputs ex_st_data (WIDTH), ex_wr_reg (3), ex_reg_write, ex_mem_read, ex_mem_write, ex_halt (1 each).
REQ-006 SHALL have inputs ex_is_set (1) and ex_setop (2): set-instruction select, 00 SEQ, 01 SLT, 10 SLE, 11 SCO.
REQ-007 SHALL have inputs stall (1), hold the register, and flush (1), squash the incoming slot.
REQ-008 SHALL have outputs mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_halt (1 each), mem_wr_reg (3), mem_result (WIDTH), mem_st_data (WIDTH).
REQ-009 SHALL have outputs flags (4, order {ZF,SF,OF,CF}) and halted (1).

Function
REQ-010 SHALL evaluate cond combinationally: SEQ=ZF; SLT=(SF^OF)&~ZF; SLE=(SF^OF)|ZF; SCO=CF.
REQ-011 SHALL form next result = ex_is_set ? zero-extended cond (bit0=cond, upper WIDTH-1 bits 0) : ex_alu_out.
REQ-012 SHALL use per-edge priority: rst > halted-state hold > flush > stall > load.
REQ-013 SHALL on load capture all ex_* fields into mem_* with latency exactly one cycle; mem_valid=ex_valid.
REQ-014 SHALL on load with ex_valid=0 force mem_reg_write, mem_mem_read, mem_mem_write, mem_halt to 0 (bubble); data fields don't-care but still captured.
REQ-015 SHALL on flush (no stall priority) load a bubble: mem_valid and all control outputs 0, mem_result and mem_st_data 0.
REQ-016 SHALL on stall (no flush) hold every output and the flag register unchanged.
REQ-017 SHALL update flags only on a load with ex_valid=1 and ex_is_set=0; bubbles, set instructions, stalls and flushes preserve flags.
REQ-018 SHALL implement FSM with states RUN and HALTED; reset state RUN.
REQ-019 SHALL transition RUN->HALTED on a load with ex_valid=1 and ex_halt=1; the halt slot itself appears on outputs that cycle (mem_valid=1, mem_halt=1).
REQ-020 SHALL in HALTED output halted=1, and from the edge after entry force mem_valid and all control outputs to 0, holding mem_result, mem_st_data, mem_wr_reg, flags.
REQ-021 SHALL in HALTED ignore ex_*, stall and flush; only rst exits HALTED.
REQ-022 SHALL in RUN output halted=0.
REQ-023 SHALL treat simultaneous stall and flush as flush.
REQ-024 SHALL contain no combinational path from any input to any output.

Reset
REQ-025 SHALL on rst assertion immediately, independent of clk, drive all mem_* outputs to 0, flags to 4'b0000, halted to 0, FSM to RUN.
REQ-026 SHALL hold reset values while rst=1 regardless of other inputs; first load occurs on the first rising edge after rst deasserts.
REQ-027 SHALL abort any in-progress halt sequence on rst mid-operation.

Verification
REQ-028 SHALL test load: ex_valid=1, alu_out=16'h1234, wr_reg=3, reg_write=1, ZF=0,SF=0,OF=0,CF=1 -> next edge mem_result=16'h1234, mem_wr_reg=3, mem_reg_write=1, flags=4'b0001.
REQ-029 SHALL test set ops: ex_is_set=1, setop=01, SF=1, OF=0, ZF=0, alu_out=16'hFFFE -> mem_result=16'h0001, flags unchanged from prior value; setop=00 with ZF=0 -> mem_result=16'h0000.
REQ-030 SHALL test stall then flush: stall=1 for 3 cycles with changing ex_* -> outputs constant; then stall=1,flush=1 -> mem_valid=0, mem_result=0, flags unchanged.
REQ-031 SHALL test halt: ex_valid=1, ex_halt=1 -> next edge mem_halt=1, mem_valid=1, halted=1; following edge with ex_valid=1, reg_write=1 -> mem_valid=0, mem_reg_write=0, halted=1.
REQ-032 SHALL test async reset: assert rst between clock edges while HALTED with mem_result=16'hBEEF -> outputs 0 and halted=0 before next edge; after release a valid load captures normally.
